// File: rtl/axi_stream_mem_client.sv
// ----------------------------------------------------------------------------
// axi_stream_mem_client
//
// Initiator side of the AXI-Stream memory command protocol. One request at a
// time is taken from the local req port and serialised onto m_axis as
// CMD, ADDR[, DATA] beats. The module then waits for the single response beat
// on s_axis and returns it on the rsp port. If no response arrives within
// TIMEOUT_CYCLES, an error response is returned instead.
//
// Ports
//   aclk, areset     clock (rising edge) / asynchronous active-high reset
//   req_*            local request port (valid/ready, write, addr, wdata)
//   rsp_*            local response port (valid/ready, rdata, error)
//   m_axis_*         outgoing command stream (tdata/tvalid/tready/tlast/tdest)
//   s_axis_*         incoming response stream (tlast is ignored)
//   busy             high whenever a request is in flight
// ----------------------------------------------------------------------------
module axi_stream_mem_client #(
    parameter int          DATA_WIDTH     = 64,
    parameter int          ADDR_WIDTH     = 8,
    parameter logic [1:0]  DEST_ID        = 2'd0,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [1:0]            m_axis_tdest,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic                  busy
);

    // Timer only needs to reach TIMEOUT_CYCLES-1; it saturates at all-ones.
    localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] WRITE_ACK = DATA_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        SEND_CMD,
        SEND_ADDR,
        SEND_DATA,
        WAIT_RSP,
        RSP_OUT
    } state_t;

    state_t                state, state_next;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [TIMER_W-1:0]    timer;
    logic                  timeout_hit;

    // Every response is a single beat, so tlast carries no information.
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;

    assign req_ready     = (state == IDLE);
    assign busy          = (state != IDLE);
    assign rsp_valid     = (state == RSP_OUT);
    assign s_axis_tready = (state != RSP_OUT);
    assign m_axis_tdest  = DEST_ID;
    assign timeout_hit   = (TIMEOUT_CYCLES != 0) && (timer == TIMER_LAST);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (req_valid)     state_next = SEND_CMD;
            SEND_CMD:  if (m_axis_tready) state_next = SEND_ADDR;
            SEND_ADDR: if (m_axis_tready) state_next = write_q ? SEND_DATA : WAIT_RSP;
            SEND_DATA: if (m_axis_tready) state_next = WAIT_RSP;
            // A response beat on the expiry cycle takes priority over the timeout.
            WAIT_RSP:  if (s_axis_tvalid || timeout_hit) state_next = RSP_OUT;
            RSP_OUT:   if (rsp_ready)     state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Outgoing beats are registered: each beat is loaded on the handshake of
    // the previous one, so tdata/tlast stay stable while the sink stalls.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            write_q       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            rsp_rdata     <= '0;
            rsp_error     <= 1'b0;
            timer         <= '0;
        end else begin
            m_axis_tvalid <= (state_next == SEND_CMD) || (state_next == SEND_ADDR) ||
                             (state_next == SEND_DATA);

            if (state == IDLE && req_valid) begin
                write_q      <= req_write;
                addr_q       <= req_addr;
                wdata_q      <= req_wdata;
                m_axis_tdata <= DATA_WIDTH'(req_write);
                m_axis_tlast <= 1'b0;
            end
            if (state == SEND_CMD && m_axis_tready) begin
                m_axis_tdata <= DATA_WIDTH'(addr_q);
                m_axis_tlast <= ~write_q;
            end
            if (state == SEND_ADDR && m_axis_tready && write_q) begin
                m_axis_tdata <= wdata_q;
                m_axis_tlast <= 1'b1;
            end

            if (state == WAIT_RSP) begin
                if (s_axis_tvalid) begin
                    rsp_rdata <= s_axis_tdata;
                    rsp_error <= write_q && (s_axis_tdata != WRITE_ACK);
                end else if (timeout_hit) begin
                    rsp_rdata <= '0;
                    rsp_error <= 1'b1;
                end
            end

            // Timer restarts from zero on every entry into WAIT_RSP.
            if (state != WAIT_RSP) begin
                timer <= '0;
            end else if (timer != '1) begin
                timer <= timer + TIMER_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_axi_stream_mem_client.sv
module tb_axi_stream_mem_client;

    logic        aclk = 1'b0;
    logic        areset;
    logic        req_valid, req_ready, req_write;
    logic [7:0]  req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_error;
    logic [63:0] rsp_rdata;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [1:0]  m_axis_tdest;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic        busy;

    int checks = 0;
    int errors = 0;

    axi_stream_mem_client #(
        .DATA_WIDTH(64), .ADDR_WIDTH(8), .DEST_ID(2'd2), .TIMEOUT_CYCLES(16)
    ) dut (
        .aclk(aclk), .areset(areset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_axis_tdest(m_axis_tdest),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .busy(busy)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle; it is accepted on the following edge.
    task automatic issue(input logic wr, input logic [7:0] addr, input logic [63:0] wdata);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        tick();
        req_valid = 1'b0;
    endtask

    logic [63:0] beats [0:7];
    int          nbeats;
    logic        prev_stall;
    logic [63:0] prev_data;

    initial begin
        areset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; m_axis_tready = 1'b0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tdest", m_axis_tdest, 2);
        areset = 1'b0;
        tick();

        // 1: write 0x05 <= 0xDEAD, sink always ready, ack = 1
        m_axis_tready = 1'b1;
        issue(1'b1, 8'h05, 64'hDEAD);
        check("t1_cmd_valid", m_axis_tvalid, 1);
        check("t1_cmd_data", m_axis_tdata, 64'h1);
        check("t1_cmd_last", m_axis_tlast, 0);
        check("t1_req_ready", req_ready, 0);
        tick();
        check("t1_addr_data", m_axis_tdata, 64'h05);
        check("t1_addr_last", m_axis_tlast, 0);
        tick();
        check("t1_data_data", m_axis_tdata, 64'hDEAD);
        check("t1_data_last", m_axis_tlast, 1);
        tick();
        check("t1_wait_tvalid", m_axis_tvalid, 0);
        check("t1_wait_busy", busy, 1);
        s_axis_tvalid = 1'b1; s_axis_tdata = 64'h1;
        tick();
        s_axis_tvalid = 1'b0;
        check("t1_rsp_valid", rsp_valid, 1);
        check("t1_rsp_rdata", rsp_rdata, 64'h1);
        check("t1_rsp_error", rsp_error, 0);
        check("t1_s_tready", s_axis_tready, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("t1_idle", req_ready, 1);
        check("t1_rsp_done", rsp_valid, 0);

        // 2: read 0xFF, response 0x1234 after a delay
        issue(1'b0, 8'hFF, 64'h0);
        check("t2_cmd_data", m_axis_tdata, 64'h0);
        check("t2_cmd_last", m_axis_tlast, 0);
        tick();
        check("t2_addr_data", m_axis_tdata, 64'hFF);
        check("t2_addr_last", m_axis_tlast, 1);
        tick();
        check("t2_wait_tvalid", m_axis_tvalid, 0);
        tick(); tick(); tick();
        check("t2_no_rsp_yet", rsp_valid, 0);
        s_axis_tvalid = 1'b1; s_axis_tdata = 64'h1234;
        tick();
        s_axis_tvalid = 1'b0;
        check("t2_rsp_valid", rsp_valid, 1);
        check("t2_rsp_rdata", rsp_rdata, 64'h1234);
        check("t2_rsp_error", rsp_error, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // 3: write with tready toggling every cycle
        m_axis_tready = 1'b0;
        issue(1'b1, 8'h33, 64'h77);
        nbeats = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        for (int i = 0; i < 16; i++) begin
            m_axis_tready = (i % 2 == 1);
            #1;
            if (prev_stall) begin
                check("t3_stall_valid", m_axis_tvalid, 1);
                check("t3_stall_data", m_axis_tdata, prev_data);
            end
            if (m_axis_tvalid && m_axis_tready && nbeats < 8) begin
                beats[nbeats] = m_axis_tdata;
                nbeats++;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            tick();
        end
        check("t3_beat_count", 64'(nbeats), 3);
        check("t3_beat0", beats[0], 64'h1);
        check("t3_beat1", beats[1], 64'h33);
        check("t3_beat2", beats[2], 64'h77);
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b1; s_axis_tdata = 64'h1;
        tick();
        s_axis_tvalid = 1'b0;
        check("t3_rsp_valid", rsp_valid, 1);
        check("t3_rsp_error", rsp_error, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // 4: read with no response -> timeout exactly 16 cycles into WAIT_RSP
        issue(1'b0, 8'h10, 64'h0);
        tick();
        tick();
        check("t4_in_wait", m_axis_tvalid, 0);
        for (int i = 0; i < 15; i++) tick();
        check("t4_not_yet", rsp_valid, 0);
        tick();
        check("t4_rsp_valid", rsp_valid, 1);
        check("t4_rsp_error", rsp_error, 1);
        check("t4_rsp_rdata", rsp_rdata, 64'h0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        s_axis_tvalid = 1'b1; s_axis_tdata = 64'hAA;
        tick();
        s_axis_tvalid = 1'b0;
        check("t4_late_no_rsp", rsp_valid, 0);
        check("t4_late_idle", busy, 0);
        issue(1'b0, 8'h22, 64'h0);
        tick();
        tick();
        s_axis_tvalid = 1'b1; s_axis_tdata = 64'h5555;
        tick();
        s_axis_tvalid = 1'b0;
        check("t4_next_rdata", rsp_rdata, 64'h5555);
        check("t4_next_error", rsp_error, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // 4b: beat arriving on the expiry cycle wins over the timeout
        issue(1'b0, 8'h11, 64'h0);
        tick();
        tick();
        for (int i = 0; i < 15; i++) tick();
        check("t4b_not_yet", rsp_valid, 0);
        s_axis_tvalid = 1'b1; s_axis_tdata = 64'hBEEF;
        tick();
        s_axis_tvalid = 1'b0;
        check("t4b_rsp_valid", rsp_valid, 1);
        check("t4b_rsp_rdata", rsp_rdata, 64'hBEEF);
        check("t4b_rsp_error", rsp_error, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // 5: write acked with 0 -> error; response held while rsp_ready low
        issue(1'b1, 8'h01, 64'h2);
        tick();
        tick();
        tick();
        s_axis_tvalid = 1'b1; s_axis_tdata = 64'h0;
        tick();
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_valid", rsp_valid, 1);
            check("t5_hold_error", rsp_error, 1);
            check("t5_hold_rdata", rsp_rdata, 64'h0);
            check("t5_hold_req_ready", req_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("t5_idle", req_ready, 1);

        // 6: reset during SEND_ADDR abandons the request
        issue(1'b0, 8'h40, 64'h0);
        tick();
        check("t6_in_addr", m_axis_tdata, 64'h40);
        areset = 1'b1;
        tick();
        check("t6_tvalid", m_axis_tvalid, 0);
        check("t6_req_ready", req_ready, 1);
        check("t6_busy", busy, 0);
        areset = 1'b0;
        tick();
        check("t6_no_rsp", rsp_valid, 0);
        issue(1'b0, 8'h41, 64'h0);
        check("t6_new_cmd", m_axis_tdata, 64'h0);
        tick();
        check("t6_new_addr", m_axis_tdata, 64'h41);
        tick();
        s_axis_tvalid = 1'b1; s_axis_tdata = 64'h9999;
        tick();
        s_axis_tvalid = 1'b0;
        check("t6_new_rsp_valid", rsp_valid, 1);
        check("t6_new_rdata", rsp_rdata, 64'h9999);
        check("t6_new_error", rsp_error, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("t6_final_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
